ascii_time_parser: RTL and testbench
====================================

Name: ascii_time_parser

Overview:
- Receive side of the watch's ASCII serial link; the counterpart to the ASCII message generator feeding the UART transmitter.
- Consumes bytes from the UART receiver and parses a time-set command of the form `T` HH MM SS CR.
- Converts the ASCII digits to packed BCD, range-checks them, and issues a one-cycle set strobe to the timekeeping counters.
- Malformed or out-of-range commands raise a one-cycle error pulse.

Parameters:
- HDR_CHAR, 8'h54, header byte that opens a command ('T').
- TERM_CHAR, 8'h0D, terminator byte (CR).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active low.
- rx_data  input  8  received byte; valid only while rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- hour_bcd  output  8  [7:4] tens, [3:0] ones of the last accepted hour.
- min_bcd  output  8  same format, minutes.
- sec_bcd  output  8  same format, seconds.
- set_valid  output  1  one-cycle pulse; new time present on the *_bcd outputs.
- parse_err  output  1  one-cycle pulse; command rejected.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - state=IDLE, digit index=0, digit buffer=0.
  - hour_bcd=min_bcd=sec_bcd=8'h00.
  - set_valid=0, parse_err=0, busy=0.
- **Bytes and digits:**
  - A byte is consumed only on a clk edge with rx_valid=1. rx_data is ignored otherwise.
  - A digit is any byte in 8'h30..8'h39. Its BCD value is rx_data[3:0].
  - The buffer holds 6 nibbles in order H1 H0 M1 M0 S1 S0.
- **States:**
  - IDLE:
    - HDR_CHAR → DIGITS, index=0.
    - Any other byte → ignored; no error, no state change.
  - DIGITS:
    - Digit → store at buffer[index]. If index=5 → TERM, else index+1.
    - HDR_CHAR → restart: index=0, stay in DIGITS, no error.
    - Any other byte → parse_err pulse, go to IDLE.
  - TERM:
    - TERM_CHAR → range check:
      - H1≤2;
      - if H1=2 then H0≤3;
      - M1≤5;
      - S1≤5.
    - Range check passes:
      - hour_bcd={H1,H0}, min_bcd={M1,M0}, sec_bcd={S1,S0};
      - set_valid=1, both on the edge after the CR beat (latency 1 clk from CR sampled);
      - go to IDLE.
    - Range check fails → parse_err pulse, *_bcd unchanged, go to IDLE.
    - HDR_CHAR → restart into DIGITS, index=0, no error.
    - Any other byte → parse_err pulse, go to IDLE.
- **Strobes:**
  - set_valid and parse_err are registered, high for exactly one cycle, and never both high.
- **Output holding:**
  - *_bcd change only alongside set_valid; otherwise they hold their last accepted value.
- **Back-to-back bytes:**
  - rx_valid high every cycle is fully supported.
  - A new HDR_CHAR on the cycle immediately after CR is accepted as a fresh command.
- **Reset mid-command:**
  - Partial buffer is discarded and *_bcd return to 00.
  - The next command must start with HDR_CHAR.
- Leading-zero digits are required; fewer than 6 digits before CR → parse_err.

Optional Feature:
- Macro: ASCII_ECHO_EN.
- When defined:
  - Adds output ports echo_data [7:0] and echo_valid [0:0] for loopback to the UART transmitter.
  - Every consumed byte, including ignored IDLE bytes, is presented on echo_data with echo_valid=1 one cycle after its rx_valid beat.
  - Reset value of both ports is 0.
- When undefined:
  - The ports and their logic are absent.
  - Parser behaviour is identical in both builds.

Test Plan:
1. Bytes 54 31 32 33 34 35 36 0D, one per cycle → one cycle after 0D: hour=12, min=34, sec=56, set_valid=1 for 1 cycle, parse_err=0.
2. 54 32 34 30 30 30 30 0D (24:00:00) → parse_err=1 for 1 cycle; *_bcd stay at the prior value 12/34/56; set_valid=0.
3. 54 30 39 41 … (non-digit 'A' at the third position) → parse_err pulse on the 'A' beat+1, busy=0. Then 54 30 39 31 35 32 30 0D → 09/15/20 set_valid.
4. 54 31 31 54 32 33 35 39 30 30 0D (header restart mid-stream) → no error; result 23/59/00, set_valid once.
5. Garbage bytes 41 0D 39 in IDLE → no pulses, busy=0. Assert rst low during the 4th digit of a valid command → *_bcd=00, busy=0 immediately; the remaining digits and 0D produce no set_valid.
6. With ASCII_ECHO_EN: stream from scenario 1 → echo_data reproduces 54…0D, each with echo_valid one cycle after its rx_valid.

Source files
------------

// File: rtl/ascii_time_parser.sv
// ASCII time-set command parser: 'T' HH MM SS CR -> packed BCD + set strobe.
// Optional byte loopback on echo_data/echo_valid when ASCII_ECHO_EN is defined.
module ascii_time_parser #(
    parameter logic [7:0] HDR_CHAR  = 8'h54,
    parameter logic [7:0] TERM_CHAR = 8'h0D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       set_valid,
    output logic       parse_err,
    output logic       busy
`ifdef ASCII_ECHO_EN
    ,
    output logic [7:0] echo_data,
    output logic       echo_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        TERM
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] buf_q, buf_d;
    logic        set_d, err_d;
    logic        is_digit;
    logic        range_ok;

    assign is_digit = (rx_data[7:4] == 4'h3) && (rx_data[3:0] <= 4'd9);

    // Hour 00-23, minutes and seconds 00-59; ones digits are already 0-9.
    assign range_ok = (buf_q[23:20] <= 4'd2) &&
                      !((buf_q[23:20] == 4'd2) && (buf_q[19:16] > 4'd3)) &&
                      (buf_q[15:12] <= 4'd5) &&
                      (buf_q[7:4] <= 4'd5);

    assign busy = (state_q != IDLE);

    // Next-state, digit capture and strobe decisions.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        set_d   = 1'b0;
        err_d   = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == HDR_CHAR) begin
                        state_d = DIGITS;
                        idx_d   = 3'd0;
                    end
                end
                DIGITS: begin
                    if (is_digit) begin
                        for (int i = 0; i < 6; i++) begin
                            if (idx_q == i[2:0]) begin
                                buf_d[(5 - i) * 4 +: 4] = rx_data[3:0];
                            end
                        end
                        if (idx_q == 3'd5) begin
                            state_d = TERM;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else if (rx_data == HDR_CHAR) begin
                        idx_d = 3'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                TERM: begin
                    if (rx_data == TERM_CHAR) begin
                        set_d   = range_ok;
                        err_d   = !range_ok;
                        state_d = IDLE;
                    end else if (rx_data == HDR_CHAR) begin
                        state_d = DIGITS;
                        idx_d   = 3'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Parser state, digit buffer, registered strobes and held time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            buf_q     <= 24'h0;
            set_valid <= 1'b0;
            parse_err <= 1'b0;
            hour_bcd  <= 8'h00;
            min_bcd   <= 8'h00;
            sec_bcd   <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            set_valid <= set_d;
            parse_err <= err_d;
            if (set_d) begin
                hour_bcd <= buf_q[23:16];
                min_bcd  <= buf_q[15:8];
                sec_bcd  <= buf_q[7:0];
            end
        end
    end

`ifdef ASCII_ECHO_EN
    // Loop every consumed byte back one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_data  <= 8'h00;
            echo_valid <= 1'b0;
        end else begin
            echo_valid <= rx_valid;
            if (rx_valid) begin
                echo_data <= rx_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ascii_time_parser.sv
// Scoreboard bench for ascii_time_parser.
// Expected strobes are queued as commands are driven and matched on output.
module tb_ascii_time_parser;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       set_valid;
    logic       parse_err;
    logic       busy;
`ifdef ASCII_ECHO_EN
    logic [7:0] echo_data;
    logic       echo_valid;
    logic [7:0] echo_q[$];
`endif

    typedef struct {
        logic [1:0] kind;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        int         cyc;
    } ev_t;

    ev_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    logic [7:0] hh, mm, ss;

    ascii_time_parser dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .hour_bcd(hour_bcd),
        .min_bcd(min_bcd),
        .sec_bcd(sec_bcd),
        .set_valid(set_valid),
        .parse_err(parse_err),
        .busy(busy)
`ifdef ASCII_ECHO_EN
        ,
        .echo_data(echo_data),
        .echo_valid(echo_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Match each strobe against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && (set_valid || parse_err)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", {30'd0, set_valid, parse_err}, 32'd0);
            end else begin
                ev_t e;
                e = sbq.pop_front();
                chk("kind", {30'd0, set_valid, parse_err}, {30'd0, e.kind});
                chk("latency", cyc, e.cyc);
                chk("hour", hour_bcd, e.h);
                chk("min", min_bcd, e.m);
                chk("sec", sec_bcd, e.s);
                chk("busy_after", busy, 0);
            end
        end
    end

`ifdef ASCII_ECHO_EN
    always @(negedge clk) begin
        if (rst && echo_valid) begin
            if (echo_q.size() == 0) begin
                chk("echo_unexp", 1, 0);
            end else begin
                chk("echo", echo_data, echo_q.pop_front());
            end
        end
    end
`endif

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
`ifdef ASCII_ECHO_EN
        echo_q.push_back(b);
`endif
    endtask

    task automatic send_str(input string str);
        for (int i = 0; i < str.len(); i++) begin
            send_byte(str[i]);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (n - 1) @(posedge clk);
    endtask

    // kind: 2 = set_valid, 1 = parse_err; called right after the final byte.
    task automatic expect_ev(input logic [1:0] k, input logic [7:0] h,
                             input logic [7:0] m, input logic [7:0] s);
        ev_t e;
        if (k == 2'd2) begin
            hh = h;
            mm = m;
            ss = s;
        end
        e.kind = k;
        e.h    = hh;
        e.m    = mm;
        e.s    = ss;
        e.cyc  = cyc + 1;
        sbq.push_back(e);
    endtask

    initial begin
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        hh = 8'h00;
        mm = 8'h00;
        ss = 8'h00;
        #12;
        chk("rst_hour", hour_bcd, 8'h00);
        chk("rst_min", min_bcd, 8'h00);
        chk("rst_sec", sec_bcd, 8'h00);
        chk("rst_set", set_valid, 0);
        chk("rst_err", parse_err, 0);
        chk("rst_busy", busy, 0);
`ifdef ASCII_ECHO_EN
        chk("rst_echo_v", echo_valid, 0);
        chk("rst_echo_d", echo_data, 8'h00);
`endif
        #10;
        rst = 1'b1;

        send_str("T123456\r");
        expect_ev(2'd2, 8'h12, 8'h34, 8'h56);
        idle(3);

        send_str("T240000\r");
        expect_ev(2'd1, 0, 0, 0);
        idle(2);

        send_str("T09A");
        expect_ev(2'd1, 0, 0, 0);
        send_str("T091520\r");
        expect_ev(2'd2, 8'h09, 8'h15, 8'h20);
        idle(2);

        send_str("T11T235900\r");
        expect_ev(2'd2, 8'h23, 8'h59, 8'h00);
        idle(2);

        send_str("T");
        idle(1);
        #1;
        chk("busy_in_cmd", busy, 1);

        send_str("T12345\r");
        expect_ev(2'd1, 0, 0, 0);
        send_str("T123456X");
        expect_ev(2'd1, 0, 0, 0);
        send_str("T126000\r");
        expect_ev(2'd1, 0, 0, 0);
        send_str("T120060\r");
        expect_ev(2'd1, 0, 0, 0);
        send_str("T195959\r");
        expect_ev(2'd2, 8'h19, 8'h59, 8'h59);
        send_str("T000000\r");
        expect_ev(2'd2, 8'h00, 8'h00, 8'h00);
        send_str("T235959\r");
        expect_ev(2'd2, 8'h23, 8'h59, 8'h59);
        idle(3);

        send_str("A\r9");
        idle(2);
        #1;
        chk("garbage_busy", busy, 0);

        send_str("T123");
        #2;
        rst      = 1'b0;
        rx_valid = 1'b0;
`ifdef ASCII_ECHO_EN
        echo_q.delete();
`endif
        hh = 8'h00;
        mm = 8'h00;
        ss = 8'h00;
        #1;
        chk("midrst_hour", hour_bcd, 8'h00);
        chk("midrst_min", min_bcd, 8'h00);
        chk("midrst_sec", sec_bcd, 8'h00);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        send_str("456\r");
        idle(3);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_hour", hour_bcd, 8'h00);

        send_str("T081500\r");
        expect_ev(2'd2, 8'h08, 8'h15, 8'h00);
        idle(5);

        chk("pending", sbq.size(), 0);
`ifdef ASCII_ECHO_EN
        chk("echo_pending", echo_q.size(), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
